// File: rtl/div_share_pkg.sv
// Shared types and default sizing for the divider-sharing controller.
package div_share_pkg;

  localparam int DIV_SHARE_NREQ  = 4;
  localparam int DIV_SHARE_WIDTH = 16;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ISSUE,
    ST_WAIT,
    ST_RESP
  } div_share_state_t;

endpackage

// File: rtl/div_share_ctrl_rr_pick.sv
// rr_pick: combinational round-robin selector. Searches upward from
// last+1 (wrapping) and returns the first pending request. It has no
// package dependency so it can be dropped into other arbiters as-is.
module rr_pick #(
  parameter int NREQ = 4,
  parameter int IDW  = $clog2(NREQ)
) (
  input  logic [NREQ-1:0] req,
  input  logic [IDW-1:0]  last,
  output logic [NREQ-1:0] gnt_onehot,
  output logic [IDW-1:0]  gnt_idx,
  output logic            any
);

  int             pos;
  logic [IDW-1:0] idx;

  // Rotate the search start to just past the previous winner and take the first hit
  always_comb begin
    gnt_onehot = '0;
    gnt_idx    = '0;
    any        = 1'b0;
    pos        = 0;
    idx        = '0;
    for (int i = 1; i <= NREQ; i++) begin
      pos = (int'(last) + i) % NREQ;
      idx = IDW'(pos);
      if (!any && req[idx]) begin
        any             = 1'b1;
        gnt_idx         = idx;
        gnt_onehot[idx] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/div_share_ctrl.sv
// div_share_ctrl: shares one divider among NREQ requesters with a
// round-robin req/ack front end and a tagged one-hot response.
// Optional feature macro: DIV_SHARE_ZERO_BYPASS_EN (divide-by-zero jobs
// skip the divider and return Q=0, R=dividend one cycle after the ack).
module div_share_ctrl
  import div_share_pkg::*;
#(
  parameter int NREQ  = DIV_SHARE_NREQ,
  parameter int WIDTH = DIV_SHARE_WIDTH,
  parameter int IDW   = $clog2(NREQ)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [NREQ-1:0]       req,
  input  logic [NREQ*WIDTH-1:0] req_dividend,
  input  logic [NREQ*WIDTH-1:0] req_divisor,
  output logic [NREQ-1:0]       req_ack,
  output logic [NREQ-1:0]       rsp_valid,
  output logic [IDW-1:0]        rsp_id,
  output logic [WIDTH-1:0]      rsp_quotient,
  output logic [WIDTH-1:0]      rsp_remainder,
  output logic                  busy,
  output logic                  div_start,
  output logic [WIDTH-1:0]      div_dividend,
  output logic [WIDTH-1:0]      div_divisor,
  input  logic [WIDTH-1:0]      div_quotient,
  input  logic [WIDTH-1:0]      div_remainder,
  input  logic                  div_valid
);

  localparam logic [NREQ-1:0] ONE_HOT0 = NREQ'(1);

  div_share_state_t state, next_state;

  logic [IDW-1:0]   last;
  logic [IDW-1:0]   cur_id;
  logic [NREQ-1:0]  pick_onehot;
  logic [IDW-1:0]   pick_idx;
  logic             pick_any;
  logic [WIDTH-1:0] pick_dividend;
  logic [WIDTH-1:0] pick_divisor;
  logic             grant_en;
  logic             start_en;
  logic             capture_en;
`ifdef DIV_SHARE_ZERO_BYPASS_EN
  logic             zero_job;
  logic             bypass_grant;
  logic             bypass_resp;
`endif

  rr_pick #(
    .NREQ (NREQ),
    .IDW  (IDW)
  ) u_pick (
    .req        (req),
    .last       (last),
    .gnt_onehot (pick_onehot),
    .gnt_idx    (pick_idx),
    .any        (pick_any)
  );

  // Select the operands belonging to the requester the picker would grant
  always_comb begin
    pick_dividend = req_dividend[int'(pick_idx)*WIDTH +: WIDTH];
    pick_divisor  = req_divisor[int'(pick_idx)*WIDTH +: WIDTH];
  end

  assign busy = (state != ST_IDLE);

  // FSM state register
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= ST_IDLE;
    end else begin
      state <= next_state;
    end
  end

  // Next-state and one-cycle strobes; the start strobe lands in the cycle after
  // ISSUE, so the WAIT cycle carrying div_start is treated as the issue cycle
  always_comb begin
    next_state = state;
    grant_en   = 1'b0;
    start_en   = 1'b0;
    capture_en = 1'b0;
`ifdef DIV_SHARE_ZERO_BYPASS_EN
    bypass_grant = 1'b0;
    bypass_resp  = 1'b0;
`endif
    case (state)
      ST_IDLE: begin
        if (pick_any) begin
          grant_en = 1'b1;
`ifdef DIV_SHARE_ZERO_BYPASS_EN
          if (pick_divisor == '0) begin
            bypass_grant = 1'b1;
            next_state   = ST_RESP;
          end else begin
            next_state = ST_ISSUE;
          end
`else
          next_state = ST_ISSUE;
`endif
        end
      end
      ST_ISSUE: begin
        start_en   = 1'b1;
        next_state = ST_WAIT;
      end
      ST_WAIT: begin
        if (div_valid && !div_start) begin
          capture_en = 1'b1;
          next_state = ST_RESP;
        end
      end
      ST_RESP: begin
`ifdef DIV_SHARE_ZERO_BYPASS_EN
        bypass_resp = zero_job;
`endif
        next_state = ST_IDLE;
      end
      default: next_state = ST_IDLE;
    endcase
  end

  // Registered outputs: grant bookkeeping, operand latch, result capture
  always_ff @(posedge clk) begin
    if (rst) begin
      last          <= IDW'(NREQ - 1);
      cur_id        <= '0;
      req_ack       <= '0;
      rsp_valid     <= '0;
      rsp_id        <= '0;
      rsp_quotient  <= '0;
      rsp_remainder <= '0;
      div_start     <= 1'b0;
      div_dividend  <= '0;
      div_divisor   <= '0;
`ifdef DIV_SHARE_ZERO_BYPASS_EN
      zero_job      <= 1'b0;
`endif
    end else begin
      req_ack   <= '0;
      rsp_valid <= '0;
      div_start <= start_en;
      if (grant_en) begin
        req_ack      <= pick_onehot;
        cur_id       <= pick_idx;
        last         <= pick_idx;
        div_dividend <= pick_dividend;
        div_divisor  <= pick_divisor;
`ifdef DIV_SHARE_ZERO_BYPASS_EN
        zero_job     <= bypass_grant;
`endif
      end
      if (capture_en) begin
        rsp_quotient  <= div_quotient;
        rsp_remainder <= div_remainder;
        rsp_valid     <= ONE_HOT0 << cur_id;
        rsp_id        <= cur_id;
      end
`ifdef DIV_SHARE_ZERO_BYPASS_EN
      if (bypass_resp) begin
        rsp_quotient  <= '0;
        rsp_remainder <= div_dividend;
        rsp_valid     <= ONE_HOT0 << cur_id;
        rsp_id        <= cur_id;
      end
`endif
    end
  end

endmodule

// File: tb/tb_div_share_ctrl.sv
// Directed bench for div_share_ctrl with a behavioural divider of
// programmable latency. Outputs are sampled #1 after each rising edge.
module tb_div_share_ctrl;

  localparam int NREQ  = 4;
  localparam int WIDTH = 16;
  localparam int IDW   = 2;

  logic                  clk = 1'b0;
  logic                  rst = 1'b1;
  logic [NREQ-1:0]       req = '0;
  logic [NREQ*WIDTH-1:0] req_dividend = '0;
  logic [NREQ*WIDTH-1:0] req_divisor = '0;
  logic [NREQ-1:0]       req_ack;
  logic [NREQ-1:0]       rsp_valid;
  logic [IDW-1:0]        rsp_id;
  logic [WIDTH-1:0]      rsp_quotient;
  logic [WIDTH-1:0]      rsp_remainder;
  logic                  busy;
  logic                  div_start;
  logic [WIDTH-1:0]      div_dividend;
  logic [WIDTH-1:0]      div_divisor;
  logic [WIDTH-1:0]      div_quotient;
  logic [WIDTH-1:0]      div_remainder;
  logic                  div_valid;

  int checks = 0;
  int errors = 0;
  int div_lat = 17;
  logic stray_valid = 1'b0;
  logic [NREQ-1:0] ack_or = '0;
  logic [NREQ-1:0] rsp_or = '0;
  logic start_seen = 1'b0;

  logic             pend = 1'b0;
  int               cnt = 0;
  logic [WIDTH-1:0] opa = '0;
  logic [WIDTH-1:0] opb = '0;
  logic             model_valid = 1'b0;
  logic [WIDTH-1:0] model_q = '0;
  logic [WIDTH-1:0] model_r = '0;

  assign div_quotient  = model_q;
  assign div_remainder = model_r;
  assign div_valid     = model_valid | stray_valid;

  div_share_ctrl #(.NREQ(NREQ), .WIDTH(WIDTH)) dut (
    .clk           (clk),
    .rst           (rst),
    .req           (req),
    .req_dividend  (req_dividend),
    .req_divisor   (req_divisor),
    .req_ack       (req_ack),
    .rsp_valid     (rsp_valid),
    .rsp_id        (rsp_id),
    .rsp_quotient  (rsp_quotient),
    .rsp_remainder (rsp_remainder),
    .busy          (busy),
    .div_start     (div_start),
    .div_dividend  (div_dividend),
    .div_divisor   (div_divisor),
    .div_quotient  (div_quotient),
    .div_remainder (div_remainder),
    .div_valid     (div_valid)
  );

  always #5 clk = ~clk;

  // Behavioural divider: valid pulses div_lat cycles after the start cycle
  always @(posedge clk) begin
    #2;
    model_valid = 1'b0;
    if (rst) begin
      pend = 1'b0;
    end else if (div_start) begin
      pend = 1'b1;
      cnt  = div_lat;
      opa  = div_dividend;
      opb  = div_divisor;
    end else if (pend) begin
      cnt = cnt - 1;
      if (cnt == 0) begin
        pend        = 1'b0;
        model_valid = 1'b1;
        if (opb == '0) begin
          model_q = '1;
          model_r = opa;
        end else begin
          model_q = opa / opb;
          model_r = opa % opb;
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
    ack_or = ack_or | req_ack;
    rsp_or = rsp_or | rsp_valid;
    if (div_start) start_seen = 1'b1;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic applyStimulus(input int k, input logic [WIDTH-1:0] dvd, input logic [WIDTH-1:0] dvs);
    req_dividend[k*WIDTH +: WIDTH] = dvd;
    req_divisor[k*WIDTH +: WIDTH]  = dvs;
    req[k] = 1'b1;
  endtask

  task automatic doReset();
    rst = 1'b1;
    req = '0;
    tick();
    tick();
    rst = 1'b0;
  endtask

  task automatic waitAck(input string tag, input int id);
    int n;
    n = 0;
    while (req_ack == '0 && n < 60) begin
      tick();
      n++;
    end
    checkOutput(tag, 32'(req_ack), 32'(4'b0001 << id));
  endtask

  task automatic serveOne(input int id, input logic [WIDTH-1:0] exp_q, input logic [WIDTH-1:0] exp_r);
    int n;
    waitAck("serve_ack", id);
    req[id] = 1'b0;
    n = 0;
    while (rsp_valid == '0 && n < 60) begin
      tick();
      n++;
    end
    checkOutput("serve_rsp_valid", 32'(rsp_valid), 32'(4'b0001 << id));
    checkOutput("serve_rsp_id", 32'(rsp_id), 32'(id));
    checkOutput("serve_quotient", 32'(rsp_quotient), 32'(exp_q));
    checkOutput("serve_remainder", 32'(rsp_remainder), 32'(exp_r));
  endtask

  initial begin
    int  cyc;
    logic got;

    // Reset state
    doReset();
    checkOutput("rst_busy", 32'(busy), 32'd0);
    checkOutput("rst_req_ack", 32'(req_ack), 32'd0);
    checkOutput("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    checkOutput("rst_div_start", 32'(div_start), 32'd0);
    checkOutput("rst_rsp_q", 32'(rsp_quotient), 32'd0);
    checkOutput("rst_div_dvd", 32'(div_dividend), 32'd0);

    // Single requester, 100/7 with L=17
    div_lat = 17;
    applyStimulus(0, 16'd100, 16'd7);
    tick();
    checkOutput("a_ack_c0", 32'(req_ack), 32'h1);
    checkOutput("a_busy_c0", 32'(busy), 32'd1);
    checkOutput("a_start_c0", 32'(div_start), 32'd0);
    req[0] = 1'b0;
    tick();
    checkOutput("a_start_c1", 32'(div_start), 32'd1);
    checkOutput("a_dvd_c1", 32'(div_dividend), 32'd100);
    checkOutput("a_dvs_c1", 32'(div_divisor), 32'd7);
    repeat (17) tick();
    checkOutput("a_rsp_c18", 32'(rsp_valid), 32'd0);
    tick();
    checkOutput("a_rsp_c19", 32'(rsp_valid), 32'h1);
    checkOutput("a_q", 32'(rsp_quotient), 32'd14);
    checkOutput("a_r", 32'(rsp_remainder), 32'd2);
    checkOutput("a_id", 32'(rsp_id), 32'd0);
    tick();
    checkOutput("a_rsp_pulse", 32'(rsp_valid), 32'd0);
    checkOutput("a_q_held", 32'(rsp_quotient), 32'd14);
    checkOutput("a_idle", 32'(busy), 32'd0);

    // All four at once after reset: order 0,1,2,3, then 0 before 1 with last=3
    doReset();
    div_lat = 3;
    applyStimulus(0, 16'd65535, 16'd255);
    applyStimulus(1, 16'd1000, 16'd10);
    applyStimulus(2, 16'd50, 16'd8);
    applyStimulus(3, 16'd7, 16'd9);
    serveOne(0, 16'd257, 16'd0);
    serveOne(1, 16'd100, 16'd0);
    serveOne(2, 16'd6, 16'd2);
    serveOne(3, 16'd0, 16'd7);
    applyStimulus(1, 16'd255, 16'd16);
    applyStimulus(0, 16'd200, 16'd3);
    serveOne(0, 16'd66, 16'd2);
    serveOne(1, 16'd15, 16'd15);

    // Withdrawal while busy and operand stability
    applyStimulus(3, 16'd40, 16'd6);
    waitAck("c_ack3", 3);
    req[3] = 1'b0;
    req_dividend[3*WIDTH +: WIDTH] = 16'd999;
    req_divisor[3*WIDTH +: WIDTH]  = 16'd1;
    applyStimulus(2, 16'd30, 16'd4);
    ack_or = '0;
    got = 1'b0;
    for (int i = 0; i < 8; i++) begin
      tick();
      if (i == 1) req[2] = 1'b0;
      if (busy) begin
        checkOutput("c_dvd_stable", 32'(div_dividend), 32'd40);
        checkOutput("c_dvs_stable", 32'(div_divisor), 32'd6);
      end
      if (rsp_valid != '0) begin
        got = 1'b1;
        checkOutput("c_rsp_valid", 32'(rsp_valid), 32'h8);
        checkOutput("c_q", 32'(rsp_quotient), 32'd6);
        checkOutput("c_r", 32'(rsp_remainder), 32'd4);
      end
    end
    checkOutput("c_got_rsp", 32'(got), 32'd1);
    checkOutput("c_no_ack_withdrawn", 32'(ack_or), 32'd0);
    checkOutput("c_idle", 32'(busy), 32'd0);

    // Stray valid during IDLE, ISSUE and the start cycle is ignored
    div_lat = 5;
    stray_valid = 1'b1;
    tick();
    checkOutput("d_idle_busy", 32'(busy), 32'd0);
    checkOutput("d_idle_rsp", 32'(rsp_valid), 32'd0);
    applyStimulus(0, 16'd81, 16'd9);
    tick();
    checkOutput("d_ack", 32'(req_ack), 32'h1);
    checkOutput("d_rsp_c0", 32'(rsp_valid), 32'd0);
    req[0] = 1'b0;
    tick();
    checkOutput("d_rsp_c1", 32'(rsp_valid), 32'd0);
    stray_valid = 1'b0;
    tick();
    checkOutput("d_rsp_c2", 32'(rsp_valid), 32'd0);
    checkOutput("d_busy_c2", 32'(busy), 32'd1);
    cyc = 2;
    while (rsp_valid == '0 && cyc < 40) begin
      tick();
      cyc++;
    end
    checkOutput("d_rsp_cycle", 32'(cyc), 32'd7);
    checkOutput("d_q", 32'(rsp_quotient), 32'd9);
    checkOutput("d_r", 32'(rsp_remainder), 32'd0);

    // Divide by zero, 1234/0
    div_lat = 3;
    applyStimulus(1, 16'd1234, 16'd0);
    waitAck("e_ack", 1);
    req[1] = 1'b0;
    start_seen = 1'b0;
    cyc = 0;
    while (rsp_valid == '0 && cyc < 40) begin
      tick();
      cyc++;
    end
    checkOutput("e_rsp_valid", 32'(rsp_valid), 32'h2);
    checkOutput("e_r", 32'(rsp_remainder), 32'd1234);
`ifdef DIV_SHARE_ZERO_BYPASS_EN
    checkOutput("e_rsp_cycle", 32'(cyc), 32'd1);
    checkOutput("e_start_seen", 32'(start_seen), 32'd0);
    checkOutput("e_q", 32'(rsp_quotient), 32'd0);
`else
    checkOutput("e_rsp_cycle", 32'(cyc), 32'd5);
    checkOutput("e_start_seen", 32'(start_seen), 32'd1);
    checkOutput("e_q", 32'(rsp_quotient), 32'hFFFF);
`endif

    // Reset in WAIT aborts the job; requester 0 has priority afterwards
    div_lat = 10;
    applyStimulus(2, 16'd500, 16'd5);
    waitAck("f_ack2", 2);
    req[2] = 1'b0;
    tick();
    tick();
    tick();
    rst = 1'b1;
    applyStimulus(0, 16'd9, 16'd2);
    applyStimulus(3, 16'd17, 16'd5);
    tick();
    checkOutput("f_busy", 32'(busy), 32'd0);
    checkOutput("f_req_ack", 32'(req_ack), 32'd0);
    checkOutput("f_rsp_valid", 32'(rsp_valid), 32'd0);
    checkOutput("f_div_start", 32'(div_start), 32'd0);
    checkOutput("f_div_dvd", 32'(div_dividend), 32'd0);
    checkOutput("f_div_dvs", 32'(div_divisor), 32'd0);
    checkOutput("f_rsp_q", 32'(rsp_quotient), 32'd0);
    checkOutput("f_rsp_r", 32'(rsp_remainder), 32'd0);
    checkOutput("f_rsp_id", 32'(rsp_id), 32'd0);
    rst = 1'b0;
    rsp_or = '0;
    serveOne(0, 16'd4, 16'd1);
    serveOne(3, 16'd3, 16'd2);
    checkOutput("f_no_rsp_aborted", 32'(rsp_or[2]), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
